// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART definitions: controller state encoding and default widths used
// by the transmit buffer, transmitter and receiver.
package uart_tx_buffer_pkg;

    localparam int DBIT_DEFAULT   = 8;
    localparam int FIFO_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_WAIT  = 2'b10
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// Synchronous circular FIFO with registered full/empty/count flags and a
// combinational head-of-queue read port.
module fifo_sync
    import uart_tx_buffer_pkg::*;
#(
    parameter int DBIT   = DBIT_DEFAULT,
    parameter int FIFO_W = FIFO_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DBIT-1:0]   wdata,
    output logic [DBIT-1:0]   rdata,
    output logic              full,
    output logic              empty,
    output logic [FIFO_W:0]   count
);

    localparam int              DEPTH_INT = 2 ** FIFO_W;
    localparam logic [FIFO_W:0] DEPTH     = {1'b1, {FIFO_W{1'b0}}};
    localparam logic [FIFO_W:0] CNT_ONE   = (FIFO_W + 1)'(1);
    localparam logic [FIFO_W-1:0] PTR_ONE = FIFO_W'(1);

    logic [DBIT-1:0]   mem [DEPTH_INT];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W:0]   count_next;
    logic              wr_ok;
    logic              rd_ok;

    // Full is registered, so a write while full is dropped even if a pop frees a slot this cycle.
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;
    assign rdata = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CNT_ONE;
        end else if (!wr_ok && rd_ok) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == DEPTH);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO in front of a UART transmitter: a three-state controller pops one
// byte, pulses start, and waits for the transmitter's done tick.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DBIT   = DBIT_DEFAULT,
    parameter int FIFO_W = FIFO_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [DBIT-1:0]   i_wdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [FIFO_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    input  logic              i_tx_done_tick,
    output logic              o_busy
);

    tx_state_e       state_q;
    tx_state_e       state_d;
    logic            pop;
    logic [DBIT-1:0] head;

    fifo_sync #(
        .DBIT   (DBIT),
        .FIFO_W (FIFO_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .wr        (i_wr),
        .rd        (pop),
        .wdata     (i_wdata),
        .rdata     (head),
        .full      (o_full),
        .empty     (o_empty),
        .count     (o_count)
    );

    // Empty is registered, so a byte written into an empty FIFO is popped one cycle later at the earliest.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        o_tx_start = 1'b0;
        o_busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!o_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                o_tx_start = 1'b1;
                o_busy     = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (i_tx_done_tick) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            o_tx_data  <= '0;
            o_overflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_overflow <= i_wr && o_full;
            if (pop) begin
                o_tx_data <= head;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer: reset, single byte, burst to
// full/overflow, pop+write collision, ordering, pointer wrap and reset in WAIT.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr;
    logic [7:0] wdata;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done_tick;
    logic       busy;

    int         check_count = 0;
    int         pass_count  = 0;
    logic [7:0] start_log[$];

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DBIT   (8),
        .FIFO_W (4)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_wr           (wr),
        .i_wdata        (wdata),
        .o_full         (full),
        .o_empty        (empty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .i_tx_done_tick (tx_done_tick),
        .o_busy         (busy)
    );

    // Records every byte handed to the transmitter, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && tx_start === 1'b1) begin
            start_log.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        check_count++; if (count !== 5'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else pass_count++;
        check_count++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", empty); else pass_count++;
        check_count++; if (full !== 1'b0 || overflow !== 1'b0) $display("[TB] FAIL reset_flags: full=%b overflow=%b expected 0 0", full, overflow); else pass_count++;
        check_count++; if (tx_start !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL reset_fsm: start=%b busy=%b expected 0 0", tx_start, busy); else pass_count++;
        check_count++; if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); else pass_count++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        wr = 1'b1; wdata = 8'hA5;
        tick();
        wr = 1'b0;
        // A done tick while idle or starting must not disturb the transfer.
        tx_done_tick = 1'b1;
        check_count++; if (count !== 5'd1 || empty !== 1'b0 || tx_start !== 1'b0) $display("[TB] FAIL single_stored: count=%0d empty=%b start=%b expected 1 0 0", count, empty, tx_start); else pass_count++;
        tick();
        check_count++; if (tx_start !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) $display("[TB] FAIL single_start: start=%b data=%h busy=%b expected 1 a5 1", tx_start, tx_data, busy); else pass_count++;
        check_count++; if (count !== 5'd0 || empty !== 1'b1) $display("[TB] FAIL single_popped: count=%0d empty=%b expected 0 1", count, empty); else pass_count++;
        tick();
        tx_done_tick = 1'b0;
        check_count++; if (tx_start !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL single_pulse_width: start=%b busy=%b expected 0 1", tx_start, busy); else pass_count++;
        tick();
        check_count++; if (busy !== 1'b1) $display("[TB] FAIL single_wait_hold: busy=%b expected 1", busy); else pass_count++;
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        check_count++; if (busy !== 1'b0 || empty !== 1'b1) $display("[TB] FAIL single_done: busy=%b empty=%b expected 0 1", busy, empty); else pass_count++;
        tick();
    endtask

    task automatic test_burst();
        for (int i = 0; i < 17; i++) begin
            wr = 1'b1; wdata = 8'(i + 1);
            tick();
        end
        check_count++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) $display("[TB] FAIL burst_full: count=%0d full=%b ovf=%b expected 16 1 0", count, full, overflow); else pass_count++;
        check_count++; if (tx_data !== 8'h01 || busy !== 1'b1) $display("[TB] FAIL burst_first: data=%h busy=%b expected 01 1", tx_data, busy); else pass_count++;
        wdata = 8'h12;
        tick();
        wr = 1'b0;
        check_count++; if (overflow !== 1'b1 || count !== 5'd16) $display("[TB] FAIL burst_overflow: ovf=%b count=%0d expected 1 16", overflow, count); else pass_count++;
        tick();
        check_count++; if (overflow !== 1'b0) $display("[TB] FAIL burst_ovf_pulse: ovf=%b expected 0", overflow); else pass_count++;
    endtask

    task automatic test_simultaneous();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        wr = 1'b1; wdata = 8'h55;
        tick();
        wr = 1'b0;
        check_count++; if (overflow !== 1'b1 || count !== 5'd15 || full !== 1'b0) $display("[TB] FAIL simul_drop: ovf=%b count=%0d full=%b expected 1 15 0", overflow, count, full); else pass_count++;
        check_count++; if (tx_start !== 1'b1 || tx_data !== 8'h02) $display("[TB] FAIL simul_pop: start=%b data=%h expected 1 02", tx_start, tx_data); else pass_count++;
        // Drain the rest; each start must come two cycles after its done tick.
        for (int b = 3; b <= 17; b++) begin
            tick();
            tx_done_tick = 1'b1;
            tick();
            tx_done_tick = 1'b0;
            tick();
            check_count++; if (tx_start !== 1'b1 || tx_data !== 8'(b)) $display("[TB] FAIL drain_byte: start=%b data=%h expected 1 %h", tx_start, tx_data, 8'(b)); else pass_count++;
        end
        tick();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        check_count++; if (count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL drain_end: count=%0d empty=%b busy=%b expected 0 1 0", count, empty, busy); else pass_count++;
        tick();
    endtask

    task automatic test_ordering();
        logic [7:0] exp_b [5] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h5A};
        int n;
        start_log.delete();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; wdata = exp_b[i];
            tick();
        end
        wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!(busy === 1'b1 && tx_start === 1'b0) && n < 30) begin
                tick();
                n++;
            end
            check_count++; if (n >= 30) $display("[TB] FAIL order_timeout: waited %0d cycles, required < 30", n); else pass_count++;
            repeat ($urandom_range(0, 4)) tick();
            check_count++; if (start_log.size() !== k + 1) $display("[TB] FAIL order_one_start: starts=%0d expected %0d", start_log.size(), k + 1); else pass_count++;
            tx_done_tick = 1'b1;
            tick();
            tx_done_tick = 1'b0;
        end
        tick();
        tick();
        check_count++; if (start_log.size() !== 5) $display("[TB] FAIL order_total: starts=%0d expected 5", start_log.size()); else pass_count++;
        for (int k = 0; k < 5 && k < start_log.size(); k++) begin
            check_count++; if (start_log[k] !== exp_b[k]) $display("[TB] FAIL order_byte%0d: got %h expected %h", k, start_log[k], exp_b[k]); else pass_count++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        int         mcnt = 0;
        int         mst = 0;
        int         wn = 0;
        int         bad = 0;
        logic       wr_ok;
        logic       pop;
        start_log.delete();
        for (int cyc = 0; cyc < 130; cyc++) begin
            wr = (cyc % 3 == 0) && (wn < 40);
            wdata = 8'(wn * 7 + 3);
            tx_done_tick = (mst == 2);
            wr_ok = wr && (mcnt < 16);
            pop = (mst == 0) && (mcnt > 0);
            if (wr) begin
                exp_q.push_back(wdata);
                wn++;
            end
            mcnt = mcnt + int'(wr_ok) - int'(pop);
            case (mst)
                0: if (pop) mst = 1;
                1: mst = 2;
                default: if (tx_done_tick) mst = 0;
            endcase
            tick();
            check_count++;
            if (count !== 5'(mcnt)) begin
                bad++;
                if (bad < 5) $display("[TB] FAIL wrap_count: cycle %0d got %0d expected %0d", cyc, count, mcnt);
            end else pass_count++;
        end
        wr = 1'b0;
        tx_done_tick = 1'b0;
        check_count++; if (start_log.size() !== 40) $display("[TB] FAIL wrap_total: starts=%0d expected 40", start_log.size()); else pass_count++;
        for (int k = 0; k < 40 && k < start_log.size(); k++) begin
            check_count++; if (start_log[k] !== exp_q[k]) $display("[TB] FAIL wrap_byte%0d: got %h expected %h", k, start_log[k], exp_q[k]); else pass_count++;
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; wdata = 8'hE0 + 8'(i);
            tick();
        end
        wr = 1'b0;
        check_count++; if (count !== 5'd3 || busy !== 1'b1 || tx_start !== 1'b0) $display("[TB] FAIL rstwait_pre: count=%0d busy=%b start=%b expected 3 1 0", count, busy, tx_start); else pass_count++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_count++; if (count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0 || tx_data !== 8'h00) $display("[TB] FAIL rstwait_clear: count=%0d empty=%b busy=%b data=%h expected 0 1 0 00", count, empty, busy, tx_data); else pass_count++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tx_start !== 1'b0) seen_start = 1'b1;
        end
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tx_start !== 1'b0 || busy !== 1'b0) seen_start = 1'b1;
            tick();
        end
        check_count++; if (seen_start !== 1'b0) $display("[TB] FAIL rstwait_stray_done: start seen=%b expected 0", seen_start); else pass_count++;
    endtask

    initial begin
        reset_n      = 1'b0;
        wr           = 1'b0;
        wdata        = 8'h00;
        tx_done_tick = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_simultaneous();
        test_ordering();
        test_wrap();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
